// File: rtl/div_unit_if.sv
// Issue/result bundle between the execute stage and the iterative RV32M divider.
interface div_unit_if #(parameter int unsigned XLEN = 32);
  logic            start_i;
  logic            kill_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, kill_i, funct3_i, rs1_i, rs2_i,
    input  busy_o, valid_o, result_o
  );

  modport slave (
    input  start_i, kill_i, funct3_i, rs1_i, rs2_i,
    output busy_o, valid_o, result_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_FAST_SPECIAL_EN to resolve divide-by-zero and signed overflow at accept.
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  div_unit_if.slave  dif
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
`ifdef DIV_FAST_SPECIAL_EN
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            isrem_q, isrem_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;

  logic            is_signed;
  logic            accept;
  logic            special;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN-1:0] rem_sh_lo;
  logic [XLEN:0]   sub;
  logic            trial_ge;
  logic [XLEN-1:0] q_fix, r_fix;

  assign is_signed = ~dif.funct3_i[0];
  assign abs_a     = (is_signed && dif.rs1_i[XLEN-1]) ? -dif.rs1_i : dif.rs1_i;
  assign abs_b     = (is_signed && dif.rs2_i[XLEN-1]) ? -dif.rs2_i : dif.rs2_i;
  assign accept    = dif.start_i & ~dif.kill_i & dif.funct3_i[2]
                   & ((state_q == IDLE) | (state_q == DONE));

  // The shifted-out remainder MSB makes the trial subtract succeed regardless of
  // the low XLEN bits, so only XLEN bits plus a borrow are needed.
  assign rem_sh_lo = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
  assign sub       = {1'b0, rem_sh_lo} - {1'b0, dvs_q};
  assign trial_ge  = rem_q[XLEN-1] | ~sub[XLEN];
  assign q_fix     = (qneg_q && (dvs_q != '0)) ? -quo_q : quo_q;
  assign r_fix     = rneg_q ? -rem_q : rem_q;

  always_comb begin
    special = 1'b0;
`ifdef DIV_FAST_SPECIAL_EN
    special = (dif.rs2_i == '0) || (is_signed && (dif.rs1_i == SMIN) && (dif.rs2_i == '1));
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      isrem_q  <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      isrem_q  <= isrem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = special ? FIX : CALC;
      CALC:    if (cnt_q == CW'(1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = accept ? (special ? FIX : CALC) : IDLE;
      default: state_d = IDLE;
    endcase
    if (dif.kill_i) state_d = IDLE;
  end

  always_comb begin
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    isrem_d  = isrem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    if (accept) begin
      rem_d   = '0;
      quo_d   = abs_a;
      dvs_d   = abs_b;
      cnt_d   = CW'(XLEN);
      isrem_d = dif.funct3_i[1];
      qneg_d  = is_signed & (dif.rs1_i[XLEN-1] ^ dif.rs2_i[XLEN-1]);
      rneg_d  = is_signed & dif.rs1_i[XLEN-1];
`ifdef DIV_FAST_SPECIAL_EN
      // Preload the magnitudes FIX would have produced; its sign rules finish the job.
      if (dif.rs2_i == '0) begin
        quo_d = '1;
        rem_d = abs_a;
      end else if (special) begin
        quo_d = SMIN;
        rem_d = '0;
      end
`endif
    end else if (state_q == CALC) begin
      rem_d = trial_ge ? sub[XLEN-1:0] : rem_sh_lo;
      quo_d = {quo_q[XLEN-2:0], trial_ge};
      cnt_d = cnt_q - CW'(1);
    end else if ((state_q == FIX) && !dif.kill_i) begin
      result_d = isrem_q ? r_fix : q_fix;
    end
  end

  always_comb begin
    dif.busy_o   = (state_q == CALC) || (state_q == FIX);
    dif.valid_o  = (state_q == DONE);
    dif.result_o = result_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a negedge monitor checks them.
module tb_div_unit;
  localparam int unsigned XLEN = 32;
  localparam int FULL_LAT = 34;
`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPC_LAT = 2;
`else
  localparam int SPC_LAT = 34;
`endif
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  div_unit_if #(.XLEN(XLEN)) dif();
  div_unit #(.XLEN(XLEN)) dut (.clk(clk), .reset_n(reset_n), .dif(dif));

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          t0;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_valid = 1'b0;
    end else begin
      if (dif.valid_o) begin
        check("valid_single_cycle", {31'b0, prev_valid}, 32'd0);
        if (sbq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_valid: got result %h, expected no valid", dif.result_o);
        end else begin
          e = sbq.pop_front();
          check(e.name, dif.result_o, e.res);
          check({e.name, "_latency"}, cyc - e.t0 + 1, e.lat);
        end
      end
      prev_valid = dif.valid_o;
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] exp, input int lat, input string name);
    dif.start_i  = 1'b1;
    dif.funct3_i = f3;
    dif.rs1_i    = a;
    dif.rs2_i    = b;
    @(posedge clk);
    #1;
    if (push) sbq.push_back('{res: exp, lat: lat, t0: cyc, name: name});
    check({name, "_busy_after_accept"}, {31'b0, dif.busy_o}, 32'd1);
    @(negedge clk);
    dif.start_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sbq.size() == 0 && !dif.busy_o && !dif.valid_o) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_drained"}, {31'b0, done}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    dif.start_i  = 1'b0;
    dif.kill_i   = 1'b0;
    dif.funct3_i = 3'b000;
    dif.rs1_i    = '0;
    dif.rs2_i    = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, dif.busy_o}, 32'd0);
    check("reset_valid", {31'b0, dif.valid_o}, 32'd0);
    check("reset_result", dif.result_o, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Back-to-back issue from DONE.
    issue(F_DIV, 32'd100, 32'd7, 1'b1, 32'd14, FULL_LAT, "div_100_7");
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (dif.valid_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("b2b_first_done", {31'b0, seen}, 32'd1);
    issue(F_REM, -32'sd100, 32'd7, 1'b1, 32'hFFFF_FFFE, FULL_LAT, "rem_m100_7_b2b");
    wait_idle("b2b");

    issue(F_DIVU, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'h7FFF_FFFF, FULL_LAT, "divu_max_2");  wait_idle("v1");
    issue(F_REMU, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'd1, FULL_LAT, "remu_max_2");          wait_idle("v2");
    issue(F_DIV, -32'sd7, 32'd2, 1'b1, 32'hFFFF_FFFD, FULL_LAT, "div_m7_2");          wait_idle("v3");
    issue(F_REM, -32'sd7, 32'd2, 1'b1, 32'hFFFF_FFFF, FULL_LAT, "rem_m7_2");          wait_idle("v4");
    issue(F_DIV, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, SPC_LAT, "div_5_0");              wait_idle("v5");
    issue(F_DIVU, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, SPC_LAT, "divu_5_0");            wait_idle("v6");
    issue(F_REMU, 32'd5, 32'd0, 1'b1, 32'd5, SPC_LAT, "remu_5_0");                    wait_idle("v7");
    issue(F_REM, -32'sd5, 32'd0, 1'b1, 32'hFFFF_FFFB, SPC_LAT, "rem_m5_0");           wait_idle("v8");
    issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, SPC_LAT, "div_ovf"); wait_idle("v9");
    issue(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, SPC_LAT, "rem_ovf");      wait_idle("v10");
    issue(F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, FULL_LAT, "divu_big");   wait_idle("v11");
    issue(F_DIVU, 32'd1000, 32'd10, 1'b1, 32'd100, FULL_LAT, "divu_1000_10");         wait_idle("v12");

    // Kill mid-CALC, then immediate reissue.
    issue(F_DIV, 32'd100, 32'd7, 1'b0, 32'd0, 0, "div_killed");
    repeat (9) @(negedge clk);
    dif.kill_i = 1'b1;
    @(posedge clk);
    #1;
    check("kill_busy", {31'b0, dif.busy_o}, 32'd0);
    check("kill_valid", {31'b0, dif.valid_o}, 32'd0);
    check("kill_result_held", dif.result_o, 32'd100);
    @(negedge clk);
    dif.kill_i = 1'b0;
    issue(F_DIVU, 32'd9, 32'd3, 1'b1, 32'd3, FULL_LAT, "divu_9_3_after_kill");
    wait_idle("after_kill");

    // Kill wins over a simultaneous start.
    dif.start_i = 1'b1; dif.kill_i = 1'b1; dif.funct3_i = F_DIV;
    dif.rs1_i = 32'd50; dif.rs2_i = 32'd5;
    @(posedge clk);
    #1;
    check("kill_over_start_busy", {31'b0, dif.busy_o}, 32'd0);
    @(negedge clk);
    dif.start_i = 1'b0; dif.kill_i = 1'b0;

    // Invalid funct3 is ignored.
    dif.start_i = 1'b1; dif.funct3_i = 3'b011;
    @(posedge clk);
    #1;
    check("bad_funct3_busy", {31'b0, dif.busy_o}, 32'd0);
    @(negedge clk);
    dif.start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("bad_funct3_result_held", dif.result_o, 32'd3);

    // Start while busy is ignored.
    issue(F_DIV, 32'd100, 32'd7, 1'b1, 32'd14, FULL_LAT, "div_with_ignored_start");
    repeat (5) @(negedge clk);
    dif.start_i = 1'b1; dif.funct3_i = F_DIVU; dif.rs1_i = 32'd9; dif.rs2_i = 32'd3;
    @(posedge clk);
    #1;
    check("ignored_start_busy", {31'b0, dif.busy_o}, 32'd1);
    @(negedge clk);
    dif.start_i = 1'b0;
    wait_idle("ignored_start");
    repeat (5) @(negedge clk);

    // Asynchronous reset mid-CALC.
    issue(F_DIVU, 32'd9, 32'd3, 1'b0, 32'd0, 0, "divu_reset");
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_busy", {31'b0, dif.busy_o}, 32'd0);
    check("midreset_valid", {31'b0, dif.valid_o}, 32'd0);
    check("midreset_result", dif.result_o, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
